boss_bullet_pool: RTL and testbench
===================================

// Module: boss_bullet_pool
// PURPOSE
//  Parametrised boss bullet engine: pool of N_BULLETS slots, each with a position and a signed velocity.
//  A fire request spawns a pattern (fan / aimed / bounce-drop) into free slots.
//  The block moves bullets once per frame tick, reflects them off side walls and retires them at the field edge.
//  It detects hits against the player hitbox and reports them to the life/score logic.
//  Sits between the boss controller and the VGA sprite mux.
// PARAMETERS
//  N_BULLETS  8    number of slots (2..16)
//  COORD_W    10   coordinate width, unsigned
//  VEL_W      6    signed velocity width per axis
//  XMIN/XMAX  30/410  side-wall reflect limits
//  YMIN/YMAX  8/472   vertical retire limits
//  BOUNCE_Y   450  floor reflect line for mode BOUNCE
//  HIT_HX     11   hitbox half-width around player (x)
//  HIT_HY     11   hitbox half-height around player (y)
//  AIM_SHIFT  4    aimed vx = (tx-ox)>>>AIM_SHIFT, saturated to VEL_W
// PORTS
//  clk22      in  1  game clock
//  rst_n      in  1  asynchronous reset, active-low
//  enable     in  1  boss phase active; 0 = synchronous clear of all slots
//  step       in  1  frame tick; positions advance only when 1
//  fire       in  1  one-cycle spawn request
//  mode       in  2  0 FAN, 1 AIMED, 2 BOUNCE, 3 reserved (ignored, no spawn)
//  origin_x/y in  COORD_W  spawn point (boss position)
//  target_x/y in  COORD_W  player position (aim + hitbox centre)
//  bullet_vld out N_BULLETS  slot occupied
//  bullet_x   out N_BULLETS*COORD_W  slot i at [i*COORD_W +: COORD_W]
//  bullet_y   out N_BULLETS*COORD_W  same packing
//  hit        out 1  one-cycle pulse, >=1 slot hit player
//  hit_mask   out N_BULLETS  slots that hit this cycle
//  drop       out 1  one-cycle pulse, spawn truncated for lack of free slots
//  active_cnt out $clog2(N_BULLETS+1)  popcount of bullet_vld
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, all velocities 0, all bounced flags 0.
//  enable=0: same clear at next edge; fire/step ignored.
//  Spawn: fire at edge t -> new slots valid at t+1, pos = origin, velocity from pattern.
//   FAN: 5 bullets, velocities (-8,+4)(-9,+3)(0,+10)(+9,+3)(+8,+4).
//   AIMED: 1 bullet, vx = sat(signed(tx-ox)>>>AIM_SHIFT), vy = +5.
//   BOUNCE: 1 bullet, (0,+10), bounced=0.
//   Allocation: pattern entries go to lowest-index free slots in pattern order.
//   Too few free slots: fill what is free, drop the rest, pulse drop.
//  Move (step=1, slot valid, not spawning this cycle):
//   next = pos + sign-extended vel in COORD_W+1 bits.
//  Wall reflect: x<XMIN with vx<0, or x>XMAX with vx>0 -> vx negated; position still updates.
//  BOUNCE slot: y>BOUNCE_Y and !bounced -> vy negated, bounced=1; second floor crossing retires slot.
//  Retire: next y<YMIN, next y>YMAX, or sign/carry overflow of next x/y -> vld=0 next cycle.
//  Hit: compares registered pos |x-tx|<HIT_HX && |y-ty|<HIT_HY, valid slots only, every cycle (not gated by step).
//   A hit slot sets its hit_mask bit, pulses hit and clears vld at the next edge.
//   A hit takes priority over move/retire.
//  Priority in one cycle: reset > enable=0 > hit > spawn into free slot > move/retire.
//  A slot freed this cycle is not reusable until the next cycle.
//  Spawn and step in the same cycle: existing bullets move; new bullets appear at origin, unmoved.
//  mode=3 with fire: no spawn, no drop.
// STRUCTURE
//  boss_bullet_pkg: mode enum, FAN table (count + vx/vy ROM), sat/abs helpers.
//  bullet_slot sub-module: one instance per slot (pos, vel, bounced, reflect/retire/hit logic).
//  Top level: free-slot priority allocator, pattern expansion, popcount, output packing.
// TESTING
//  Reset mid-flight: 3 slots active, rst_n low 1 ns off-edge -> vld=0 immediately, hit=0.
//  FAN fire at (220,100), step each cycle:
//   t+1: slots 0..4 at (220,100); t+2: slot0 at (212,104), slot2 at (220,110); active_cnt=5.
//  Wall: slot x=32, vx=-8 -> x=24 then vx=+8 -> x=32; no retire.
//  Pool full: N=8 with 5 live, fire FAN -> slots 5..7 filled, drop=1 for one cycle, active_cnt=8.
//  BOUNCE from (100,400), vy=+10: y>450 flips vy to -10; retires when y<8; no second flip.
//  Hit: bullet at (200,300), player at (205,305) -> hit=1, hit_mask bit set, slot freed next cycle.
//   Player at (211,300) -> no hit.

Source files
------------

// File: rtl/boss_bullet_pool_pkg.sv
// boss_bullet_pool_pkg: spawn-mode type, pattern tables and arithmetic helpers shared by the bullet pool
//   mode_e          fire pattern selector (FAN, AIMED, BOUNCE, reserved)
//   pattern_count   number of bullets a pattern spawns
//   entry_vx/vy     velocity of pattern entry idx
//   sat_int         clamp to a signed field of w bits
//   abs_diff        |a - b|
package boss_bullet_pool_pkg;

    typedef enum logic [1:0] {
        MODE_FAN    = 2'd0,
        MODE_AIMED  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam int FAN_CNT = 5;
    localparam int AIM_VY  = 5;
    localparam int DROP_VY = 10;

    function automatic int fan_vx(input int idx);
        case (idx)
            0:       return -8;
            1:       return -9;
            3:       return 9;
            4:       return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int fan_vy(input int idx);
        case (idx)
            0:       return 4;
            1:       return 3;
            2:       return 10;
            3:       return 3;
            4:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int pattern_count(input mode_e m);
        return m == MODE_FAN ? FAN_CNT : (m == MODE_AIMED || m == MODE_BOUNCE) ? 1 : 0;
    endfunction

    function automatic int entry_vx(input mode_e m, input int idx, input int aim);
        return m == MODE_FAN ? fan_vx(idx) : m == MODE_AIMED ? aim : 0;
    endfunction

    function automatic int entry_vy(input mode_e m, input int idx);
        return m == MODE_FAN ? fan_vy(idx) : m == MODE_AIMED ? AIM_VY : m == MODE_BOUNCE ? DROP_VY : 0;
    endfunction

    function automatic int sat_int(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return a > b ? a - b : b - a;
    endfunction

endpackage

// File: rtl/boss_bullet_pool_if.sv
// boss_bullet_pool_if: boss controller / sprite mux connection to the bullet pool
//   master: drives enable, step, fire, mode, origin_x/y, target_x/y; reads pool state
//   slave : the pool; drives bullet_vld, bullet_x/y (slot i at [i*COORD_W +: COORD_W]),
//           hit, hit_mask, drop, active_cnt
interface boss_bullet_pool_if
    import boss_bullet_pool_pkg::*;
#(
    parameter int N_BULLETS = 8,
    parameter int COORD_W   = 10
) ();
    localparam int CNT_W = $clog2(N_BULLETS + 1);

    logic                         enable;
    logic                         step;
    logic                         fire;
    mode_e                        mode;
    logic [COORD_W-1:0]           origin_x;
    logic [COORD_W-1:0]           origin_y;
    logic [COORD_W-1:0]           target_x;
    logic [COORD_W-1:0]           target_y;
    logic [N_BULLETS-1:0]         bullet_vld;
    logic [N_BULLETS*COORD_W-1:0] bullet_x;
    logic [N_BULLETS*COORD_W-1:0] bullet_y;
    logic                         hit;
    logic [N_BULLETS-1:0]         hit_mask;
    logic                         drop;
    logic [CNT_W-1:0]             active_cnt;

    modport master (
        output enable, step, fire, mode, origin_x, origin_y, target_x, target_y,
        input  bullet_vld, bullet_x, bullet_y, hit, hit_mask, drop, active_cnt
    );

    modport slave (
        input  enable, step, fire, mode, origin_x, origin_y, target_x, target_y,
        output bullet_vld, bullet_x, bullet_y, hit, hit_mask, drop, active_cnt
    );

endinterface

// File: rtl/boss_bullet_pool_slot.sv
// boss_bullet_pool_slot: one bullet slot -- position, velocity, wall/floor reflect, retire and hit test
//   clk22, rst_n           game clock, async active-low reset
//   enable                 0 clears the slot at the next edge
//   step                   frame tick, position advances only when 1
//   spawn, spawn_*         load a new bullet (only asserted while the slot is empty)
//   tx, ty                 player position, centre of the hitbox
//   vld, x, y              slot state
//   hit_q                  registered one-cycle hit pulse for this slot
module boss_bullet_pool_slot
    import boss_bullet_pool_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int VEL_W    = 6,
    parameter int XMIN     = 30,
    parameter int XMAX     = 410,
    parameter int YMIN     = 8,
    parameter int YMAX     = 472,
    parameter int BOUNCE_Y = 450,
    parameter int HIT_HX   = 11,
    parameter int HIT_HY   = 11
) (
    input  logic                      clk22,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      step,
    input  logic                      spawn,
    input  logic                      spawn_bounce,
    input  logic [COORD_W-1:0]        spawn_x,
    input  logic [COORD_W-1:0]        spawn_y,
    input  logic signed [VEL_W-1:0]   spawn_vx,
    input  logic signed [VEL_W-1:0]   spawn_vy,
    input  logic [COORD_W-1:0]        tx,
    input  logic [COORD_W-1:0]        ty,
    output logic                      vld,
    output logic [COORD_W-1:0]        x,
    output logic [COORD_W-1:0]        y,
    output logic                      hit_q
);
    localparam logic [COORD_W-1:0] XMIN_C   = COORD_W'(XMIN);
    localparam logic [COORD_W-1:0] XMAX_C   = COORD_W'(XMAX);
    localparam logic [COORD_W-1:0] YMIN_C   = COORD_W'(YMIN);
    localparam logic [COORD_W-1:0] YMAX_C   = COORD_W'(YMAX);
    localparam logic [COORD_W-1:0] BOUNCE_C = COORD_W'(BOUNCE_Y);

    logic signed [VEL_W-1:0] vx, vy, nvx, nvy;
    logic                    bmode, bounced;
    logic                    hit_now, refl_x, flip_y, floor2, retire;
    logic [COORD_W:0]        nx, ny;

    // Reflection is decided on the current position and the move already uses the reflected velocity.
    // The extra top bit of nx/ny catches both underflow below 0 and carry past the coordinate range.
    always_comb begin
        hit_now = vld && abs_diff(int'(x), int'(tx)) < HIT_HX && abs_diff(int'(y), int'(ty)) < HIT_HY;
        refl_x  = (x < XMIN_C && vx[VEL_W-1]) || (x > XMAX_C && !vx[VEL_W-1] && |vx);
        flip_y  = bmode && !bounced && y > BOUNCE_C;
        floor2  = bmode && bounced && y > BOUNCE_C;
        nvx     = refl_x ? -vx : vx;
        nvy     = flip_y ? -vy : vy;
        nx      = {1'b0, x} + {{(COORD_W + 1 - VEL_W){nvx[VEL_W-1]}}, nvx};
        ny      = {1'b0, y} + {{(COORD_W + 1 - VEL_W){nvy[VEL_W-1]}}, nvy};
        retire  = nx[COORD_W] || ny[COORD_W] || ny[COORD_W-1:0] < YMIN_C || ny[COORD_W-1:0] > YMAX_C || floor2;
    end

    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) begin
            {vld, bmode, bounced, hit_q} <= '0;
            x  <= '0;
            y  <= '0;
            vx <= '0;
            vy <= '0;
        end else if (!enable) begin
            {vld, bmode, bounced, hit_q} <= '0;
            x  <= '0;
            y  <= '0;
            vx <= '0;
            vy <= '0;
        end else begin
            hit_q <= hit_now;
            if (hit_now) begin
                vld <= 1'b0;
            end else if (spawn) begin
                vld     <= 1'b1;
                x       <= spawn_x;
                y       <= spawn_y;
                vx      <= spawn_vx;
                vy      <= spawn_vy;
                bmode   <= spawn_bounce;
                bounced <= 1'b0;
            end else if (step && vld) begin
                vld     <= !retire;
                x       <= nx[COORD_W-1:0];
                y       <= ny[COORD_W-1:0];
                vx      <= nvx;
                vy      <= nvy;
                bounced <= bounced || flip_y;
            end
        end
    end

endmodule

// File: rtl/boss_bullet_pool.sv
// boss_bullet_pool: boss bullet engine -- pattern spawn into a slot pool, per-frame motion, player hit reporting
//   clk22, rst_n   game clock, async active-low reset
//   bus (slave)    enable/step/fire/mode/origin/target in;
//                  bullet_vld, bullet_x/y, hit, hit_mask, drop, active_cnt out
module boss_bullet_pool
    import boss_bullet_pool_pkg::*;
#(
    parameter int N_BULLETS = 8,
    parameter int COORD_W   = 10,
    parameter int VEL_W     = 6,
    parameter int XMIN      = 30,
    parameter int XMAX      = 410,
    parameter int YMIN      = 8,
    parameter int YMAX      = 472,
    parameter int BOUNCE_Y  = 450,
    parameter int HIT_HX    = 11,
    parameter int HIT_HY    = 11,
    parameter int AIM_SHIFT = 4
) (
    input logic               clk22,
    input logic               rst_n,
    boss_bullet_pool_if.slave bus
);
    localparam int CNT_W = $clog2(N_BULLETS + 1);

    logic [N_BULLETS-1:0]             vld, hit_mask, spawn;
    logic [N_BULLETS-1:0][VEL_W-1:0]  svx, svy;
    logic [N_BULLETS*COORD_W-1:0]     bx, by;
    logic [CNT_W-1:0]                 cnt;
    logic                             sbounce, drop_now, drop_q;
    int                               pat_n, k, aim_vx;

    // Pattern entries go to the lowest-index empty slots in order. Only slots empty at the start of
    // the cycle count as free, so a slot hit or retired now is reused no earlier than next cycle.
    always_comb begin
        pat_n   = (bus.enable && bus.fire) ? pattern_count(bus.mode) : 0;
        aim_vx  = sat_int((int'(bus.target_x) - int'(bus.origin_x)) >>> AIM_SHIFT, VEL_W);
        sbounce = bus.mode == MODE_BOUNCE;
        spawn   = '0;
        svx     = '0;
        svy     = '0;
        k       = 0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (!vld[i] && k < pat_n) begin
                spawn[i] = 1'b1;
                svx[i]   = VEL_W'(entry_vx(bus.mode, k, aim_vx));
                svy[i]   = VEL_W'(entry_vy(bus.mode, k));
                k        = k + 1;
            end
        end
        drop_now = k < pat_n;
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_BULLETS; i++) cnt = cnt + CNT_W'(vld[i]);
    end

    always_ff @(posedge clk22 or negedge rst_n) begin
        if (!rst_n) drop_q <= 1'b0;
        else drop_q <= drop_now;
    end

    for (genvar i = 0; i < N_BULLETS; i++) begin : g_slot
        boss_bullet_pool_slot #(
            .COORD_W  (COORD_W),
            .VEL_W    (VEL_W),
            .XMIN     (XMIN),
            .XMAX     (XMAX),
            .YMIN     (YMIN),
            .YMAX     (YMAX),
            .BOUNCE_Y (BOUNCE_Y),
            .HIT_HX   (HIT_HX),
            .HIT_HY   (HIT_HY)
        ) u_slot (
            .clk22        (clk22),
            .rst_n        (rst_n),
            .enable       (bus.enable),
            .step         (bus.step),
            .spawn        (spawn[i]),
            .spawn_bounce (sbounce),
            .spawn_x      (bus.origin_x),
            .spawn_y      (bus.origin_y),
            .spawn_vx     (svx[i]),
            .spawn_vy     (svy[i]),
            .tx           (bus.target_x),
            .ty           (bus.target_y),
            .vld          (vld[i]),
            .x            (bx[i*COORD_W +: COORD_W]),
            .y            (by[i*COORD_W +: COORD_W]),
            .hit_q        (hit_mask[i])
        );
    end

    assign bus.bullet_vld = vld;
    assign bus.bullet_x   = bx;
    assign bus.bullet_y   = by;
    assign bus.hit        = |hit_mask;
    assign bus.hit_mask   = hit_mask;
    assign bus.drop       = drop_q;
    assign bus.active_cnt = cnt;

endmodule

// File: tb/tb_boss_bullet_pool.sv
// tb_boss_bullet_pool: scoreboard bench for the boss bullet pool -- expectations are queued per cycle by the stimulus and checked by a negedge monitor
module tb_boss_bullet_pool;
    import boss_bullet_pool_pkg::*;

    localparam int N  = 8;
    localparam int CW = 10;

    typedef enum int {K_VLD, K_X, K_Y, K_CNT, K_HIT, K_HMASK, K_DROP} kind_e;
    typedef struct {
        int    cyc;
        kind_e kind;
        int    idx;
        int    val;
        string name;
    } exp_t;

    logic clk22 = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    boss_bullet_pool_if #(.N_BULLETS(N), .COORD_W(CW)) bus ();

    boss_bullet_pool #(.N_BULLETS(N), .COORD_W(CW)) dut (
        .clk22 (clk22),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk22 = ~clk22;
    always @(posedge clk22) cyc <= cyc + 1;

    function automatic void exp_at(input int dc, input kind_e kind, input int idx, input int val, input string name);
        exp_t e;
        e.cyc  = cyc + dc;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endfunction

    function automatic int actual(input exp_t e);
        case (e.kind)
            K_VLD:   return int'(bus.bullet_vld);
            K_X:     return int'(bus.bullet_x[e.idx*CW +: CW]);
            K_Y:     return int'(bus.bullet_y[e.idx*CW +: CW]);
            K_CNT:   return int'(bus.active_cnt);
            K_HIT:   return int'(bus.hit);
            K_HMASK: return int'(bus.hit_mask);
            default: return int'(bus.drop);
        endcase
    endfunction

    initial forever begin
        @(negedge clk22);
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].cyc <= cyc) begin
                int a;
                a = actual(sb[j]);
                n_checks++;
                if (a == sb[j].val) n_pass++;
                else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", sb[j].name, a, sb[j].val, cyc);
                sb.delete(j);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk22);
            #1;
        end
    endtask

    task automatic launch(input mode_e m, input int ox, input int oy);
        bus.fire     = 1'b1;
        bus.mode     = m;
        bus.origin_x = CW'(ox);
        bus.origin_y = CW'(oy);
    endtask

    task automatic aim_at(input int tx, input int ty);
        bus.target_x = CW'(tx);
        bus.target_y = CW'(ty);
    endtask

    task automatic clear_pool();
        bus.enable = 1'b0;
        bus.fire   = 1'b0;
        tick();
        bus.enable = 1'b1;
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.step   = 1'b0;
        bus.fire   = 1'b0;
        bus.mode   = MODE_FAN;
        bus.origin_x = '0;
        bus.origin_y = '0;
        aim_at(1000, 1000);
        tick(2);
        exp_at(0, K_VLD, 0, 0, "rst_vld");
        exp_at(0, K_CNT, 0, 0, "rst_cnt");
        exp_at(0, K_HIT, 0, 0, "rst_hit");
        exp_at(0, K_HMASK, 0, 0, "rst_hmask");
        exp_at(0, K_DROP, 0, 0, "rst_drop");
        tick();
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        bus.step   = 1'b1;
        tick();

        // FAN at (220,100), stepping every cycle; new bullets appear unmoved
        launch(MODE_FAN, 220, 100);
        exp_at(1, K_VLD, 0, 'h1f, "fan_vld");
        exp_at(1, K_X, 0, 220, "fan_x0_spawn");
        exp_at(1, K_Y, 4, 100, "fan_y4_spawn");
        exp_at(1, K_CNT, 0, 5, "fan_cnt");
        exp_at(1, K_DROP, 0, 0, "fan_nodrop");
        exp_at(2, K_X, 0, 212, "fan_x0_step");
        exp_at(2, K_Y, 0, 104, "fan_y0_step");
        exp_at(2, K_X, 1, 211, "fan_x1_step");
        exp_at(2, K_Y, 1, 103, "fan_y1_step");
        exp_at(2, K_X, 2, 220, "fan_x2_step");
        exp_at(2, K_Y, 2, 110, "fan_y2_step");
        exp_at(2, K_X, 4, 228, "fan_x4_step");
        exp_at(2, K_CNT, 0, 5, "fan_cnt_step");
        tick();
        bus.fire = 1'b0;
        tick();

        // pool full: 5 live, another FAN fills slots 5..7 and drops two entries
        launch(MODE_FAN, 300, 200);
        exp_at(1, K_VLD, 0, 'hff, "full_vld");
        exp_at(1, K_CNT, 0, 8, "full_cnt");
        exp_at(1, K_DROP, 0, 1, "full_drop");
        exp_at(1, K_X, 5, 300, "full_x5");
        exp_at(1, K_Y, 7, 200, "full_y7");
        exp_at(1, K_X, 0, 204, "full_x0_moves");
        exp_at(2, K_DROP, 0, 0, "full_drop_pulse");
        exp_at(2, K_X, 5, 292, "full_x5_step");
        exp_at(2, K_Y, 5, 204, "full_y5_step");
        exp_at(2, K_X, 6, 291, "full_x6_step");
        exp_at(2, K_Y, 7, 210, "full_y7_step");
        exp_at(2, K_CNT, 0, 8, "full_cnt_step");
        tick();
        bus.fire = 1'b0;
        tick();

        // enable=0 clears everything and ignores fire
        bus.enable = 1'b0;
        launch(MODE_FAN, 100, 100);
        exp_at(1, K_VLD, 0, 0, "clr_vld");
        exp_at(1, K_CNT, 0, 0, "clr_cnt");
        exp_at(1, K_DROP, 0, 0, "clr_drop");
        exp_at(1, K_X, 0, 0, "clr_x0");
        tick();
        bus.enable = 1'b1;

        // left wall: x=32, vx=-8 -> 24 -> reflect -> 32 -> 40
        launch(MODE_FAN, 32, 100);
        exp_at(1, K_X, 0, 32, "wall_x0_spawn");
        exp_at(2, K_X, 0, 24, "wall_x0_in");
        exp_at(2, K_X, 1, 23, "wall_x1_in");
        exp_at(3, K_X, 0, 32, "wall_x0_out");
        exp_at(3, K_X, 1, 32, "wall_x1_out");
        exp_at(3, K_VLD, 0, 'h1f, "wall_no_retire");
        exp_at(4, K_X, 0, 40, "wall_x0_away");
        exp_at(4, K_X, 1, 41, "wall_x1_away");
        exp_at(4, K_Y, 0, 112, "wall_y0");
        tick();
        bus.fire = 1'b0;
        tick(4);
        clear_pool();

        // reserved mode: no spawn, no drop
        launch(MODE_RSVD, 100, 100);
        exp_at(1, K_VLD, 0, 0, "rsvd_vld");
        exp_at(1, K_DROP, 0, 0, "rsvd_drop");
        tick();

        // AIMED: 300>>>4 = 18; -1000>>>4 = -63 saturates to -32
        aim_at(400, 1000);
        launch(MODE_AIMED, 100, 100);
        exp_at(1, K_VLD, 0, 'h01, "aim_vld");
        exp_at(1, K_X, 0, 100, "aim_x0_spawn");
        tick();
        aim_at(0, 1000);
        launch(MODE_AIMED, 1000, 100);
        exp_at(1, K_VLD, 0, 'h03, "aim2_vld");
        exp_at(1, K_X, 0, 118, "aim_x0_step");
        exp_at(1, K_Y, 0, 105, "aim_y0_step");
        exp_at(1, K_X, 1, 1000, "aim2_x1_spawn");
        tick();
        bus.fire = 1'b0;
        exp_at(1, K_X, 1, 968, "aim2_x1_sat");
        exp_at(1, K_Y, 1, 105, "aim2_y1_step");
        exp_at(1, K_X, 0, 136, "aim_x0_step2");
        tick();
        aim_at(1000, 1000);
        clear_pool();

        // BOUNCE from (100,400): floor flip past 450, single flip, retire below YMIN
        launch(MODE_BOUNCE, 100, 400);
        exp_at(1, K_Y, 0, 400, "bnc_y_spawn");
        exp_at(7, K_Y, 0, 460, "bnc_y_floor");
        exp_at(8, K_Y, 0, 450, "bnc_y_flip");
        exp_at(9, K_Y, 0, 440, "bnc_y_up");
        exp_at(52, K_Y, 0, 10, "bnc_y_top");
        exp_at(52, K_VLD, 0, 'h01, "bnc_vld_top");
        exp_at(53, K_VLD, 0, 0, "bnc_retired");
        exp_at(53, K_CNT, 0, 0, "bnc_cnt");
        tick();
        bus.fire = 1'b0;
        tick(52);

        // hit: player 5 px off is a hit, 11 px off is not
        bus.step = 1'b0;
        launch(MODE_BOUNCE, 200, 300);
        exp_at(1, K_VLD, 0, 'h01, "hit_vld_spawn");
        exp_at(1, K_HIT, 0, 0, "hit_none_far");
        tick();
        bus.fire = 1'b0;
        aim_at(211, 300);
        exp_at(1, K_HIT, 0, 0, "hit_edge_miss");
        exp_at(1, K_VLD, 0, 'h01, "hit_edge_vld");
        tick();
        aim_at(205, 305);
        exp_at(1, K_HIT, 0, 1, "hit_pulse");
        exp_at(1, K_HMASK, 0, 'h01, "hit_mask");
        exp_at(1, K_VLD, 0, 0, "hit_freed");
        exp_at(2, K_HIT, 0, 0, "hit_one_cycle");
        exp_at(2, K_HMASK, 0, 0, "hit_mask_clear");
        tick(2);
        aim_at(1000, 1000);

        // asynchronous reset mid-flight with 3 live slots
        launch(MODE_BOUNCE, 50, 200);
        tick(3);
        bus.fire = 1'b0;
        exp_at(0, K_VLD, 0, 'h07, "mid_vld");
        exp_at(0, K_CNT, 0, 3, "mid_cnt");
        tick();
        aim_at(50, 200);
        rst_n = 1'b0;
        exp_at(0, K_VLD, 0, 0, "arst_vld");
        exp_at(0, K_CNT, 0, 0, "arst_cnt");
        exp_at(0, K_HIT, 0, 0, "arst_hit");
        tick(2);
        rst_n = 1'b1;
        tick(3);

        if (sb.size() != 0) begin
            $display("FAIL scoreboard: %0d expectations left, expected 0", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
